// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed
// SLICE bits per clock, LSB slice first, with the carry/borrow chain kept
// in a register between slices. One operation takes N = WIDTH/SLICE clocks
// and is issued through a start/busy/done handshake.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only while busy=0
//   mode   : 0 = subtract (A - B - bi), 1 = add (A + B + bi)
//   A, B   : operands, latched on accepted start
//   bi     : borrow-in / carry-in, latched on accepted start
//   busy   : operation in progress
//   done   : one-cycle pulse when d/bo/ovf update
//   d      : result, held until the next completion
//   bo     : borrow-out (sub) / carry-out (add)
//   ovf    : two's-complement signed overflow
//
// Optional feature: define SERIAL_SUB_SAT_EN for unsigned saturation of d
// (sub underflow -> 0, add overflow -> all ones). bo/ovf stay raw.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | processing slice cnt_q (0..N-1), busy=1

module serial_sub_nbit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Width of the partial-result register holding already-finished slices.
  localparam int AW = (N > 1) ? (WIDTH - SLICE) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  // Chain bit is held in carry form for both modes; subtraction is done as
  // A + ~B + ~bi, so borrow = ~carry.
  logic             chain_q, chain_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0]    a_s, bx_s, sum_s;
  logic [SLICE:0]      full_s;
  logic                cout_s, cin_msb;
  logic [SLICE+AW-1:0] cat_s;
  logic [WIDTH-1:0]    result;
  logic                last;

  always_comb begin
    a_s     = a_q[SLICE-1:0];
    bx_s    = mode_q ? b_q[SLICE-1:0] : ~b_q[SLICE-1:0];
    full_s  = {1'b0, a_s} + {1'b0, bx_s} + {{SLICE{1'b0}}, chain_q};
    sum_s   = full_s[SLICE-1:0];
    cout_s  = full_s[SLICE];
    // Carry into the slice MSB recovered from its sum bit.
    cin_msb = a_s[SLICE-1] ^ bx_s[SLICE-1] ^ full_s[SLICE-1];
    cat_s   = {sum_s, acc_q};
    result  = cat_s[SLICE+AW-1 -: WIDTH];
    last    = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    chain_d = chain_q;
    acc_d   = acc_q;
    d_d     = d_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          a_d     = A;
          b_d     = B;
          mode_d  = mode;
          chain_d = mode ? bi : ~bi;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        chain_d = cout_s;
        acc_d   = cat_s[SLICE+AW-1 -: AW];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          bo_d    = mode_q ? cout_s : ~cout_s;
          ovf_d   = cin_msb ^ cout_s;
`ifdef SERIAL_SUB_SAT_EN
          if (mode_q && cout_s)
            d_d = '1;
          else if (!mode_q && !cout_s)
            d_d = '0;
          else
            d_d = result;
`else
          d_d = result;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      chain_q <= 1'b0;
      acc_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      chain_q <= chain_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_nbit.sv
module tb_serial_sub_nbit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] A;
  logic [15:0] B;
  logic        bi;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        bo;
  logic        ovf;

  int n_chk  = 0;
  int n_fail = 0;

  serial_sub_nbit #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .A     (A),
    .B     (B),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next negedge and check the full busy/done timeline.
  task automatic run_op(input string tag, input logic m, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_d, input logic exp_bo, input logic exp_ovf);
    @(negedge clk);
    mode = m; A = a; B = b; bi = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy@k"}, 16'(busy), 16'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk({tag, " busy mid"}, 16'(busy), 16'd1);
      chk({tag, " done mid"}, 16'(done), 16'd0);
    end
    @(posedge clk); #1;
    chk({tag, " busy end"}, 16'(busy), 16'd0);
    chk({tag, " done"}, 16'(done), 16'd1);
    chk({tag, " d"}, d, exp_d);
    chk({tag, " bo"}, 16'(bo), 16'(exp_bo));
    chk({tag, " ovf"}, 16'(ovf), 16'(exp_ovf));
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 16'(done), 16'd0);
    chk({tag, " d held"}, d, exp_d);
  endtask

`ifdef SERIAL_SUB_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; A = '0; B = '0; bi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst d", d, 16'h0000);
    chk("rst bo", 16'(bo), 16'd0);
    chk("rst ovf", 16'(ovf), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sub1", 1'b0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("sub2", 1'b0, 16'h0000, 16'h0001, 1'b0, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0);
    run_op("sub3", 1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op("sub4", 1'b0, 16'h0005, 16'h0005, 1'b1, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0);
    run_op("add1", 1'b1, 16'hFFFF, 16'h0001, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b0);
    run_op("add2", 1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add3", 1'b1, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0);

    // Ignored start at edge k+2, then back-to-back start in the done cycle.
    @(negedge clk);
    mode = 1'b0; A = 16'h1234; B = 16'h0234; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // edge k
    start = 1'b0;
    @(posedge clk); #1;            // edge k+1
    mode = 1'b1; A = 16'hFFFF; B = 16'hFFFF; bi = 1'b1; start = 1'b1;
    @(posedge clk); #1;            // edge k+2
    start = 1'b0;
    chk("ign busy", 16'(busy), 16'd1);
    @(posedge clk); #1;            // edge k+3
    chk("ign done early", 16'(done), 16'd0);
    @(posedge clk); #1;            // edge k+4
    chk("ign done", 16'(done), 16'd1);
    chk("ign d", d, 16'h1000);
    chk("ign bo", 16'(bo), 16'd0);
    mode = 1'b1; A = 16'h7FFF; B = 16'h0001; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // edge k+5 accepts
    start = 1'b0;
    chk("b2b busy", 16'(busy), 16'd1);
    chk("b2b done drop", 16'(done), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b2b no early done", 16'(done), 16'd0);
    end
    @(posedge clk); #1;            // edge k+9
    chk("b2b done", 16'(done), 16'd1);
    chk("b2b d", d, 16'h8000);
    chk("b2b ovf", 16'(ovf), 16'd1);

    // Reset after two slices of a running op.
    @(negedge clk);
    mode = 1'b0; A = 16'h0000; B = 16'h0001; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-rst busy", 16'(busy), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 16'(busy), 16'd0);
    chk("arst done", 16'(done), 16'd0);
    chk("arst d", d, 16'h0000);
    chk("arst bo", 16'(bo), 16'd0);
    chk("arst ovf", 16'(ovf), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post-rst no done", 16'(done), 16'd0);
      chk("post-rst idle", 16'(busy), 16'd0);
    end
    run_op("after rst", 1'b0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
